// File: rtl/barrel_normalizer.sv
// barrel_normalizer: iterative normalizer and the inverse of the barrel shifter.
// It finds the shift that moves the first set bit to the MSB (left) or to the
// LSB (right). The search is binary, one log-step per clock.
// Both sides use valid/ready handshakes. A result is presented only once the
// search is complete. The result registers keep their last values after handoff.
module barrel_normalizer #(
  parameter int BW_DATA = 8,
  parameter int BW_K    = $clog2(BW_DATA)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BW_DATA-1:0] i_a,
  input  logic               i_left,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_y,
  output logic [BW_K-1:0]    o_k,
  output logic               o_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The final step index is S-1. S is the number of log-steps and equals BW_K.
  localparam logic [BW_K-1:0]    LAST_STEP = BW_K'(BW_K - 1);
  localparam logic [BW_K-1:0]    K_ONE     = BW_K'(1);
  localparam logic [BW_K-1:0]    K_ZERO    = {BW_K{1'b0}};
  localparam logic [BW_DATA-1:0] ALL_ONES  = {BW_DATA{1'b1}};
  localparam logic [BW_DATA-1:0] ALL_ZERO  = {BW_DATA{1'b0}};

  state_t             state_r;
  state_t             state_nxt_s;
  logic               ready_r;
  logic               valid_r;

  logic [BW_DATA-1:0] work_r;
  logic               left_r;
  logic [BW_K-1:0]    k_acc_r;
  logic [BW_K-1:0]    step_r;
  logic               zero_r;

  logic [BW_DATA-1:0] y_r;
  logic [BW_K-1:0]    k_out_r;
  logic               zero_out_r;

  logic               accept_s;
  logic               last_step_s;
  logic [BW_K-1:0]    bit_idx_s;
  logic [BW_K-1:0]    width_s;
  logic [BW_DATA-1:0] mask_s;
  logic               hit_s;
  logic [BW_DATA-1:0] work_nxt_s;
  logic [BW_K-1:0]    k_nxt_s;

  // State register. The handshake flags are registered from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
      valid_r <= (state_nxt_s == DONE);
    end
  end

  // Next-state logic: accept -> S search steps -> hold the result until it is taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (step_r == LAST_STEP) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Per-step search decode.
  // The step width is 2^(S-1-step). The step tests the outer field of that
  // width in the chosen direction. It shifts the field out only if the field is all zero.
  always_comb begin
    accept_s    = 1'b0;
    last_step_s = 1'b0;
    bit_idx_s   = K_ZERO;
    width_s     = K_ZERO;
    mask_s      = ALL_ZERO;
    hit_s       = 1'b0;
    work_nxt_s  = work_r;
    k_nxt_s     = k_acc_r;

    accept_s    = (state_r == IDLE) && i_valid;
    last_step_s = (step_r == LAST_STEP);
    bit_idx_s   = LAST_STEP - step_r;
    width_s     = K_ONE << bit_idx_s;

    if (left_r) begin
      mask_s = ~(ALL_ONES >> width_s);
    end else begin
      mask_s = ~(ALL_ONES << width_s);
    end

    hit_s = ((work_r & mask_s) == ALL_ZERO);

    if (hit_s) begin
      if (left_r) begin
        work_nxt_s = work_r << width_s;
      end else begin
        work_nxt_s = work_r >> width_s;
      end
      k_nxt_s = k_acc_r | (K_ONE << bit_idx_s);
    end else begin
      work_nxt_s = work_r;
      k_nxt_s    = k_acc_r;
    end
  end

  // Working datapath: captures the operand on acceptance and advances one step in BUSY.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      work_r  <= ALL_ZERO;
      left_r  <= 1'b0;
      k_acc_r <= K_ZERO;
      step_r  <= K_ZERO;
      zero_r  <= 1'b0;
    end else if (accept_s) begin
      work_r  <= i_a;
      left_r  <= i_left;
      k_acc_r <= K_ZERO;
      step_r  <= K_ZERO;
      zero_r  <= (i_a == ALL_ZERO);
    end else if (state_r == BUSY) begin
      work_r  <= work_nxt_s;
      k_acc_r <= k_nxt_s;
      step_r  <= step_r + K_ONE;
    end else begin
      work_r  <= work_r;
      k_acc_r <= k_acc_r;
      step_r  <= step_r;
    end
  end

  // Result registers: loaded only at the final step, so a partial result is never visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      y_r        <= ALL_ZERO;
      k_out_r    <= K_ZERO;
      zero_out_r <= 1'b0;
    end else if ((state_r == BUSY) && last_step_s) begin
      y_r        <= work_nxt_s;
      k_out_r    <= k_nxt_s;
      zero_out_r <= zero_r;
    end else begin
      y_r        <= y_r;
      k_out_r    <= k_out_r;
      zero_out_r <= zero_out_r;
    end
  end

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_y     = y_r;
  assign o_k     = k_out_r;
  assign o_zero  = zero_out_r;

endmodule

// File: tb/tb_barrel_normalizer.sv
// Directed testbench for barrel_normalizer (BW_DATA=8, three log-steps).
// Expected values are hand-computed or come from a small zero-count model.
module tb_barrel_normalizer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic       left;
  logic       out_valid;
  logic       ds_ready;
  logic [7:0] y;
  logic [2:0] k;
  logic       zero;

  int n_checks = 0;
  int n_errors = 0;

  barrel_normalizer #(.BW_DATA(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_a     (a),
    .i_left  (left),
    .o_valid (out_valid),
    .i_ready (ds_ready),
    .o_y     (y),
    .o_k     (k),
    .o_zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: count leading/trailing zeros by a linear scan.
  function automatic logic [2:0] ref_k(input logic [7:0] v, input logic l);
    int c;
    c = 0;
    if (v == 8'h00) return 3'd7;
    if (l) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) break;
        c++;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) break;
        c++;
      end
    end
    return 3'(c);
  endfunction

  // Barrel shifter used to re-derive o_y from the operand and o_k.
  function automatic logic [7:0] shifter(input logic [7:0] v, input logic l, input logic [2:0] s);
    if (l) return v << s;
    return v >> s;
  endfunction

  // Waits (bounded) until the DUT is ready. Then it drives one operand and checks
  // the latency, the result and the handoff. ds_ready is left at 1 on return.
  task automatic run_op(input string tag, input logic [7:0] op, input logic l,
                        input logic [7:0] exp_y, input logic [2:0] exp_k, input logic exp_z,
                        input bit backpressure);
    int waited;
    waited = 0;
    while (!out_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready_before"}, 32'(out_ready), 32'd1);
    ds_ready = backpressure ? 1'b0 : 1'b1;
    a = op;
    left = l;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~op;
    left = ~l;
    check({tag, "_busy_ready"}, 32'(out_ready), 32'd0);
    @(negedge clk);
    check({tag, "_valid_t1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_t2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_t3"}, 32'(out_valid), 32'd1);
    check({tag, "_y"}, 32'(y), 32'(exp_y));
    check({tag, "_k"}, 32'(k), 32'(exp_k));
    check({tag, "_zero"}, 32'(zero), 32'(exp_z));
    check({tag, "_rederive"}, 32'(shifter(op, l, k)), 32'(y));
    if (backpressure) begin
      in_valid = 1'b1;
      a = 8'hFF;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_bp_ready"}, 32'(out_ready), 32'd0);
        check({tag, "_bp_y"}, 32'(y), 32'(exp_y));
        check({tag, "_bp_k"}, 32'(k), 32'(exp_k));
      end
      in_valid = 1'b0;
      ds_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_after_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_after_ready"}, 32'(out_ready), 32'd1);
    check({tag, "_hold_y"}, 32'(y), 32'(exp_y));
    check({tag, "_hold_k"}, 32'(k), 32'(exp_k));
  endtask

  initial begin
    logic [7:0] r_op;
    logic       r_l;
    logic [2:0] r_k;

    rst = 1'b1;
    in_valid = 1'b0;
    a = 8'h00;
    left = 1'b0;
    ds_ready = 1'b1;
    #1;
    check("rst_ready", 32'(out_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("left13",  8'h13, 1'b1, 8'h98, 3'd3, 1'b0, 1'b0);
    run_op("rightA0", 8'hA0, 1'b0, 8'h05, 3'd5, 1'b0, 1'b0);
    run_op("left80",  8'h80, 1'b1, 8'h80, 3'd0, 1'b0, 1'b0);
    run_op("right80", 8'h80, 1'b0, 8'h01, 3'd7, 1'b0, 1'b0);
    run_op("left00",  8'h00, 1'b1, 8'h00, 3'd7, 1'b1, 1'b0);
    run_op("right00", 8'h00, 1'b0, 8'h00, 3'd7, 1'b1, 1'b0);
    run_op("right01", 8'h01, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);

    // Backpressure. The 8'hFF driven while in DONE must not be captured.
    run_op("bp",      8'h24, 1'b1, 8'h90, 3'd2, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_no_capture_ready", 32'(out_ready), 32'd1);
    check("bp_no_capture_valid", 32'(out_valid), 32'd0);

    // Reset asserted mid-BUSY, after step 1.
    a = 8'h03;
    left = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(out_ready), 32'd1);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_k", 32'(k), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst", 8'h06, 1'b0, 8'h03, 3'd1, 1'b0, 1'b0);

    // Random operands against the zero-count model.
    for (int i = 0; i < 32; i++) begin
      r_op = 8'($urandom_range(0, 255));
      if (i % 8 == 0) r_op = 8'h00;
      r_l  = 1'($urandom_range(0, 1));
      r_k  = ref_k(r_op, r_l);
      run_op("rand", r_op, r_l, (r_op == 8'h00) ? 8'h00 : shifter(r_op, r_l, r_k),
             r_k, (r_op == 8'h00), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/barrel_normalizer.md
Name: barrel_normalizer

Overview:
- Iterative normalizer: the inverse of the barrel shifter.
- Takes a data word and a direction, then finds the shift amount that brings the first set bit to the MSB (left) or to the LSB (right).
- Returns the normalized word and that shift amount; i.e. it recovers i_k for an un-normalized operand.
- Uses one log-step per cycle (binary search), with valid/ready handshakes on both sides. Sits ahead of the barrel shifter in normalize/denormalize datapaths.

Parameters:
- BW_DATA, 8, data width; power of two, >= 2.
- BW_K, $clog2(BW_DATA), width of the shift amount; derived, not to be overridden.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_valid  input  1  input operand valid.
- o_ready  output  1  block can accept an operand.
- i_a  input  BW_DATA  operand; sampled only on acceptance.
- i_left  input  1  direction: 1 = normalize toward MSB (count leading zeros, shift left); 0 = toward LSB (count trailing zeros, shift right). Sampled on acceptance.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_y  output  BW_DATA  normalized word.
- o_k  output  BW_K  shift amount applied.
- o_zero  output  1  operand was all zeros.

Behaviour:
- Reset:
  - Async assert forces state IDLE.
  - o_ready=1; o_valid=0; o_y=0; o_k=0; o_zero=0; internal data/step counter cleared.
  - Reset mid-operation abandons the operand; no partial result is ever presented.
- States: IDLE, BUSY, DONE. S = BW_K stages.
- IDLE:
  - o_ready=1, o_valid=0.
  - On edge with i_valid=1: latch i_a into a working register, latch i_left, clear k accumulator, step=0, go BUSY.
- BUSY:
  - o_ready=0, o_valid=0.
  - At step s, width w = 2^(S-1-s).
  - Left: if the top w bits of the working register are 0, shift left by w (zero fill) and set bit (S-1-s) of k.
  - Right: test the bottom w bits instead and shift right by w (zero fill).
  - step increments each edge. After the edge processing step S-1, go DONE.
- DONE:
  - o_valid=1; o_y/o_k/o_zero hold the result, stable until handoff.
  - On edge with i_ready=1: go IDLE; o_valid falls; o_y/o_k/o_zero keep their last values.
  - i_ready=0 holds the result indefinitely.
- o_ready is high only in IDLE. i_valid outside IDLE is ignored; the operand is not captured.
- Latency: operand accepted at edge t gives o_valid=1 after edge t+S. Minimum period per operand is S+2 cycles (accept, S steps, handoff).
- Result invariants for nonzero operand:
  - o_y equals i_a shifted by o_k in the i_left direction.
  - o_y[BW_DATA-1]=1 when left; o_y[0]=1 when right.
  - o_zero=0.
- Zero operand: every stage shifts, so o_k=BW_DATA-1, o_y=0, o_zero=1. o_zero is computed from the latched operand at acceptance.
- Changes on i_a/i_left after acceptance have no effect.

Test Plan (BW_DATA=8, S=3):
- Left normalize: i_a=8'h13, i_left=1, i_ready=1 -> o_valid exactly 3 edges after accept; o_y=8'h98, o_k=3, o_zero=0; o_valid low the following cycle.
- Right normalize: i_a=8'hA0, i_left=0 -> o_y=8'h05, o_k=5, o_zero=0.
- Boundaries:
  - i_a=8'h80, left -> o_y=8'h80, o_k=0.
  - i_a=8'h80, right -> o_y=8'h01, o_k=7.
  - i_a=8'h00, either direction -> o_y=0, o_k=7, o_zero=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while driving i_valid=1, i_a=8'hFF -> o_valid=1, outputs stable, o_ready=0. Raise i_ready -> IDLE next edge; the 8'hFF operand was not captured.
- Reset mid-BUSY: assert i_rst asynchronously after step 1 -> o_valid=0, o_ready=1, o_y=0, o_k=0 immediately. A new operand afterwards completes correctly.
- Randomized: 30+ random operands/directions checked against a reference model (leading/trailing-zero count + shift). Verify each o_y re-derives from i_a via the barrel shifter with i_k=o_k; zero error count reported.
